// File: rtl/address_gen_pkg.sv
// rtl/address_gen_pkg.sv - shared state encoding and mode constants for the 2-D address generator
package address_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESET = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/address_gen_2d_if.sv
// rtl/address_gen_2d_if.sv - address stream handshake bundle between generator and memory front end
interface address_gen_2d_if #(
  parameter int ADDR_W = 16
);

  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              addr_ready;

  modport master (output addr, output addr_valid, input addr_ready);
  modport slave  (input addr, input addr_valid, output addr_ready);

endinterface

// File: rtl/address_gen_wrap_cnt.sv
// rtl/address_gen_wrap_cnt.sv - clearable counter that wraps to zero after reaching a programmable terminal value
module address_gen_wrap_cnt #(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [LEN_W-1:0] term,
  output logic             at_term
);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;

  assign at_term = (cnt_q == term);

  // Clear wins over increment; an increment at the terminal value rolls over to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = at_term ? '0 : cnt_q + LEN_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/address_gen_2d.sv
// rtl/address_gen_2d.sv - 2-D strided address generator with preset/run/done control FSM
module address_gen_2d
  import address_gen_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [LEN_W-1:0]      col_len,
  input  logic [LEN_W-1:0]      row_len,
  input  logic [ADDR_W-1:0]     row_stride,
  address_gen_2d_if.master      bus,
  output logic                  preset_flag,
  output logic                  frame_done,
  output logic                  busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [LEN_W-1:0]  col_len_q, col_len_d;
  logic [LEN_W-1:0]  row_len_q, row_len_d;
  logic              mode_q, mode_d;
  logic              frame_done_q, frame_done_d;

  logic handshake;
  logic col_inc;
  logic row_inc;
  logic cnt_clr;
  logic col_at_term;
  logic row_at_term;

  // Status outputs are pure decodes of the state register, so no input reaches them combinationally.
  assign bus.addr       = addr_q;
  assign bus.addr_valid = (state_q == ST_RUN);
  assign preset_flag    = (state_q == ST_IDLE) || (state_q == ST_PRESET);
  assign busy           = (state_q == ST_PRESET) || (state_q == ST_RUN);
  assign frame_done     = frame_done_q;

  // An abort (en low) suppresses the handshake so counters never advance on the aborting edge.
  assign handshake = en && (state_q == ST_RUN) && bus.addr_ready;
  assign col_inc   = handshake;
  assign row_inc   = handshake && col_at_term;
  assign cnt_clr   = !en || (state_q != ST_RUN);

  address_gen_wrap_cnt #(.LEN_W(LEN_W)) u_col_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc     (col_inc),
    .term    (col_len_q - LEN_W'(1)),
    .at_term (col_at_term)
  );

  address_gen_wrap_cnt #(.LEN_W(LEN_W)) u_row_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc     (row_inc),
    .term    (row_len_q - LEN_W'(1)),
    .at_term (row_at_term)
  );

  // Next-state, shadow-register and address-adder logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    row_base_d   = row_base_q;
    stride_d     = stride_q;
    col_len_d    = col_len_q;
    row_len_d    = row_len_q;
    mode_d       = mode_q;
    frame_done_d = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_PRESET;
        end
        ST_PRESET: begin
          mode_d     = mode;
          col_len_d  = col_len;
          row_len_d  = row_len;
          stride_d   = row_stride;
          addr_d     = base_addr;
          row_base_d = base_addr;
          if ((col_len == '0) || (row_len == '0)) begin
            frame_done_d = 1'b1;
            state_d      = (mode == MODE_SINGLE) ? ST_DONE : ST_PRESET;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.addr_ready) begin
            if (col_at_term && row_at_term) begin
              frame_done_d = 1'b1;
              state_d      = (mode_q == MODE_CONT) ? ST_PRESET : ST_DONE;
            end else if (col_at_term) begin
              row_base_d = row_base_q + stride_q;
              addr_d     = row_base_q + stride_q;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      row_base_q   <= '0;
      stride_q     <= '0;
      col_len_q    <= '0;
      row_len_q    <= '0;
      mode_q       <= MODE_CONT;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      row_base_q   <= row_base_d;
      stride_q     <= stride_d;
      col_len_q    <= col_len_d;
      row_len_q    <= row_len_d;
      mode_q       <= mode_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_address_gen_2d.sv
// tb/tb_address_gen_2d.sv - scoreboard bench for address_gen_2d with randomized frames and ready patterns
module tb_address_gen_2d;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [15:0] base_addr;
  logic [9:0]  col_len;
  logic [9:0]  row_len;
  logic [15:0] row_stride;
  logic        preset_flag;
  logic        frame_done;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int fd_count    = 0;

  logic [15:0] exp_q[$];
  logic        hold_pending = 1'b0;
  logic [15:0] held_addr    = '0;

  address_gen_2d_if #(.ADDR_W(16)) bif ();

  address_gen_2d #(.ADDR_W(16), .LEN_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .base_addr   (base_addr),
    .col_len     (col_len),
    .row_len     (row_len),
    .row_stride  (row_stride),
    .bus         (bif.master),
    .preset_flag (preset_flag),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the frame is simply base + r*stride + c, row-major, modulo 2^16.
  task automatic push_frame(input logic [15:0] b, input int c, input int r, input logic [15:0] s);
    for (int ri = 0; ri < r; ri++) begin
      for (int ci = 0; ci < c; ci++) begin
        int unsigned v;
        v = int'(b) + ri * int'(s) + ci;
        exp_q.push_back(v[15:0]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] b, input int c, input int r, input logic [15:0] s,
                         input logic m);
    base_addr  = b;
    col_len    = 10'(c);
    row_len    = 10'(r);
    row_stride = s;
    mode       = m;
  endtask

  // Monitor: pops the scoreboard on every accepted address and checks stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) fd_count++;
      if (bif.addr_valid) begin
        if (hold_pending) check("stall_stable", bif.addr, held_addr);
        if (bif.addr_ready) begin
          hold_pending = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_addr", bif.addr, 32'hdead_beef);
          end else begin
            check("addr", bif.addr, exp_q.pop_front());
          end
        end else begin
          hold_pending = 1'b1;
          held_addr    = bif.addr;
        end
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  // Single-shot frame: rmode 0 = ready high, 1 = toggle, 2 = random.
  task automatic run_frame(input logic [15:0] b, input int c, input int r, input logic [15:0] s,
                           input int rmode, input bit chk_lat);
    int start;
    set_cfg(b, c, r, s, 1'b1);
    push_frame(b, c, r, s);
    start = fd_count;
    bif.addr_ready = 1'b1;
    en = 1'b1;
    if (chk_lat) begin
      tick();
      check("lat_preset_valid", bif.addr_valid, 1'b0);
      check("lat_preset_busy", busy, 1'b1);
      tick();
      check("lat_first_valid", bif.addr_valid, 1'b1);
      check("lat_first_addr", bif.addr, b);
    end
    for (int i = 0; i < 500; i++) begin
      tick();
      if (fd_count > start) break;
      if (rmode == 1) bif.addr_ready = ~bif.addr_ready;
      else if (rmode == 2) bif.addr_ready = 1'($urandom_range(0, 1));
    end
    bif.addr_ready = 1'b1;
    repeat (3) tick();
    check("done_pulses", fd_count, start + 1);
    check("done_queue_empty", exp_q.size(), 0);
    check("done_preset_flag", preset_flag, 1'b0);
    check("done_busy", busy, 1'b0);
    check("done_valid", bif.addr_valid, 1'b0);
    en = 1'b0;
    tick();
    check("idle_preset_flag", preset_flag, 1'b1);
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    en = 1'b0;
    bif.addr_ready = 1'b1;
    set_cfg(16'h0, 0, 0, 16'h0, 1'b0);
    repeat (3) tick();
    check("rst_valid", bif.addr_valid, 1'b0);
    check("rst_preset_flag", preset_flag, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_addr", bif.addr, 16'h0);
    rst = 1'b0;
    tick();

    run_frame(16'h0100, 3, 2, 16'h0010, 0, 1'b1);
    run_frame(16'h0100, 3, 2, 16'h0010, 1, 1'b0);
    run_frame(16'hFFFE, 4, 1, 16'h0000, 0, 1'b0);

    // Continuous mode: three frames, one PRESET bubble between each.
    set_cfg(16'h0020, 2, 1, 16'h0000, 1'b0);
    push_frame(16'h0020, 2, 1, 16'h0);
    push_frame(16'h0020, 2, 1, 16'h0);
    push_frame(16'h0020, 2, 1, 16'h0);
    bif.addr_ready = 1'b1;
    en = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (frame_done) begin
        n++;
        check("cont_bubble_valid", bif.addr_valid, 1'b0);
        check("cont_bubble_preset", preset_flag, 1'b1);
        if (n == 3) begin
          en = 1'b0;
          break;
        end
      end
    end
    check("cont_frames", n, 3);
    tick();
    tick();
    check("cont_queue_empty", exp_q.size(), 0);
    check("cont_idle_valid", bif.addr_valid, 1'b0);

    // Empty single-shot frame.
    set_cfg(16'h0300, 0, 3, 16'h0004, 1'b1);
    en = 1'b1;
    tick();
    check("empty_fd_early", frame_done, 1'b0);
    tick();
    check("empty_fd", frame_done, 1'b1);
    check("empty_done_flag", preset_flag, 1'b0);
    check("empty_valid", bif.addr_valid, 1'b0);
    tick();
    check("empty_fd_single", frame_done, 1'b0);
    check("empty_busy", busy, 1'b0);
    en = 1'b0;
    tick();
    tick();

    // Abort mid-row while a handshake is offered, then restart from base.
    set_cfg(16'h1234, 4, 2, 16'h0040, 1'b1);
    push_frame(16'h1234, 4, 2, 16'h0040);
    while (exp_q.size() > 6) void'(exp_q.pop_back());
    bif.addr_ready = 1'b1;
    en = 1'b1;
    repeat (2 + 5) tick();
    en = 1'b0;
    tick();
    check("abort_valid", bif.addr_valid, 1'b0);
    check("abort_preset_flag", preset_flag, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_frame_done", frame_done, 1'b0);
    check("abort_queue_empty", exp_q.size(), 0);
    tick();
    run_frame(16'h1234, 4, 2, 16'h0040, 0, 1'b1);

    // Randomized single-shot frames with random backpressure.
    for (int k = 0; k < 8; k++) begin
      run_frame(16'($urandom), int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
                16'($urandom), 2, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
